// File: rtl/mult_defs.sv
// Shared encodings for the shift-and-add multiplier controller and its bench.
package mult_defs;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/shift_add_mult_ctrl_adder.sv
// N-bit ripple-carry adder; the single shared datapath adder of the multiplier.
module AdderNbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned N x N shift-and-add multiplier: one add per cycle for N
// cycles, then a one-cycle done pulse with the registered 2N-bit product.
module shift_add_mult_ctrl
    import mult_defs::*;
#(
    parameter  int N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    logic [1:0]    state;
    logic [N-1:0]  m_reg;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  q_reg;
    logic [CW-1:0] cnt;

    logic [N-1:0]  add_b;
    logic [N-1:0]  sum;
    logic          carry;

    assign add_b = q_reg[0] ? m_reg : '0;

    AdderNbit #(.N(N)) u_adder (
        .a    (a_reg),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            m_reg   <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= '0;
                        cnt   <= CW'(N);
                        state <= ST_CALC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    // Right shift of {carry, sum, Q}: carry lands in A's MSB, sum LSB enters Q.
                    a_reg <= {carry, sum[N-1:1]};
                    q_reg <= {sum[0], q_reg[N-1:1]};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        product <= {carry, sum, q_reg[N-1:1]};
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
